cci_mpf_csr_event_counters: RTL and testbench

Parametrised event-counter bank that replaces the hard-wired per-shim event sums in the MPF CSR manager. It accepts N single-cycle event pulses from shims such as VTP hit/miss and walk-busy, and accumulates each in its own counter. The CSR manager can atomically snapshot all counters, read any one of them by index, and clear any subset of them. It has a sticky overflow flag per counter.

---
 rtl/cci_mpf_csr_event_counters_if.sv | 28 ++
 rtl/cci_mpf_csr_event_counters.sv | 107 ++++++++++
 tb/tb_cci_mpf_csr_event_counters.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cci_mpf_csr_event_counters_if.sv
// Bundle between the MPF CSR manager / event shims (master) and the event-counter bank (slave).
// Requests carry no ready: the bank accepts every rd_req, and rd_rsp_valid pulses exactly one cycle later.
interface cci_mpf_csr_event_counters_if #(
    parameter int N_EVENTS      = 5,
    parameter int COUNTER_WIDTH = 64,
    parameter int IDX_W         = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1
);
    logic [N_EVENTS-1:0]      events_in;
    logic                     clear_req;
    logic [N_EVENTS-1:0]      clear_mask;
    logic                     snapshot_req;
    logic                     rd_req;
    logic [IDX_W-1:0]         rd_idx;
    logic                     rd_rsp_valid;
    logic [COUNTER_WIDTH-1:0] rd_rsp_data;
    logic                     rd_rsp_overflow;
    logic                     snapshot_done;

    modport master (
        output events_in, clear_req, clear_mask, snapshot_req, rd_req, rd_idx,
        input  rd_rsp_valid, rd_rsp_data, rd_rsp_overflow, snapshot_done
    );

    modport slave (
        input  events_in, clear_req, clear_mask, snapshot_req, rd_req, rd_idx,
        output rd_rsp_valid, rd_rsp_data, rd_rsp_overflow, snapshot_done
    );
endinterface

// File: rtl/cci_mpf_csr_event_counters.sv
// Event-counter bank with atomic snapshot into a shadow bank, indexed shadow read and masked clear.
// Define CCI_MPF_EVENT_CTR_SATURATE_EN to make counters saturate at all-ones instead of wrapping.
module cci_mpf_csr_event_counters #(
    parameter int N_EVENTS       = 5,
    parameter int COUNTER_WIDTH  = 64,
    parameter int N_INPUT_STAGES = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    cci_mpf_csr_event_counters_if.slave csr
);
    localparam logic [COUNTER_WIDTH-1:0] CTR_ONES = '1;
    localparam logic [COUNTER_WIDTH-1:0] CTR_ONE  = COUNTER_WIDTH'(1);

    logic [N_EVENTS-1:0] qual_events;

    generate
        if (N_INPUT_STAGES == 0) begin : g_no_stage
            assign qual_events = csr.events_in;
        end else begin : g_stages
            logic [N_EVENTS-1:0] stage_q [N_INPUT_STAGES];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int s = 0; s < N_INPUT_STAGES; s++) stage_q[s] <= '0;
                end else begin
                    stage_q[0] <= csr.events_in;
                    for (int s = 1; s < N_INPUT_STAGES; s++) stage_q[s] <= stage_q[s-1];
                end
            end

            assign qual_events = stage_q[N_INPUT_STAGES-1];
        end
    endgenerate

    logic [COUNTER_WIDTH-1:0] live_q   [N_EVENTS];
    logic [COUNTER_WIDTH-1:0] live_d   [N_EVENTS];
    logic [COUNTER_WIDTH-1:0] shadow_q [N_EVENTS];
    logic [N_EVENTS-1:0]      ovf_q;
    logic [N_EVENTS-1:0]      ovf_d;

    // Clear has priority: a qualified event landing on a cleared channel is dropped.
    always_comb begin
        for (int i = 0; i < N_EVENTS; i++) begin
            live_d[i] = live_q[i];
            ovf_d[i]  = ovf_q[i];
            if (csr.clear_req && csr.clear_mask[i]) begin
                live_d[i] = '0;
                ovf_d[i]  = 1'b0;
            end else if (qual_events[i]) begin
`ifdef CCI_MPF_EVENT_CTR_SATURATE_EN
                if (live_q[i] == CTR_ONES) ovf_d[i] = 1'b1;
                else live_d[i] = live_q[i] + CTR_ONE;
`else
                if (live_q[i] == CTR_ONES) ovf_d[i] = 1'b1;
                live_d[i] = live_q[i] + CTR_ONE;
`endif
            end
        end
    end

    // Shadow captures live_q, i.e. the value before this cycle's increment or clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_EVENTS; i++) begin
                live_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < N_EVENTS; i++) begin
                live_q[i] <= live_d[i];
                if (csr.snapshot_req) shadow_q[i] <= live_q[i];
            end
            ovf_q <= ovf_d;
        end
    end

    logic                     idx_in_range;
    logic                     rsp_valid_q;
    logic [COUNTER_WIDTH-1:0] rsp_data_q;
    logic                     rsp_ovf_q;
    logic                     snap_done_q;

    assign idx_in_range = int'(csr.rd_idx) < N_EVENTS;

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
            snap_done_q <= 1'b0;
        end else begin
            rsp_valid_q <= csr.rd_req;
            snap_done_q <= csr.snapshot_req;
            if (csr.rd_req) begin
                rsp_data_q <= idx_in_range ? shadow_q[csr.rd_idx] : '0;
                rsp_ovf_q  <= idx_in_range ? ovf_q[csr.rd_idx] : 1'b0;
            end
        end
    end

    assign csr.rd_rsp_valid    = rsp_valid_q;
    assign csr.rd_rsp_data     = rsp_data_q;
    assign csr.rd_rsp_overflow = rsp_ovf_q;
    assign csr.snapshot_done   = snap_done_q;
endmodule

// File: tb/tb_cci_mpf_csr_event_counters.sv
// Bench for cci_mpf_csr_event_counters: table of count/snapshot/read vectors plus hand sequences
// for latency, clear-vs-event, out-of-range reads and mid-run reset.
module tb_cci_mpf_csr_event_counters;
    localparam int N  = 5;
    localparam int W  = 8;
    localparam int IW = 3;
`ifdef CCI_MPF_EVENT_CTR_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [W-1:0] D256 = SAT ? 8'd255 : 8'd0;
    localparam logic [W-1:0] D300 = SAT ? 8'd255 : 8'd44;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cci_mpf_csr_event_counters_if #(.N_EVENTS(N), .COUNTER_WIDTH(W)) bus ();

    cci_mpf_csr_event_counters #(
        .N_EVENTS(N), .COUNTER_WIDTH(W), .N_INPUT_STAGES(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .csr   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [W:0] exp_q[$];

    typedef struct {
        logic [N-1:0]  mask;
        int            pulses;
        logic [IW-1:0] idx;
        logic [W-1:0]  data;
        logic          ovf;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: requests sampled at the active edge, responses checked 1 time unit later.
    logic req_s, snap_s;
    logic [W:0] e;
    always @(posedge clk) begin
        req_s  = bus.rd_req && !reset;
        snap_s = bus.snapshot_req && !reset;
        #1;
        if (req_s || bus.rd_rsp_valid === 1'b1)
            check("rd_rsp_valid", 64'(bus.rd_rsp_valid), 64'(req_s));
        if (bus.rd_rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: got response data %0h with no read outstanding", bus.rd_rsp_data);
            end else begin
                e = exp_q.pop_front();
                check("rd_rsp_data", 64'(bus.rd_rsp_data), 64'(e[W-1:0]));
                check("rd_rsp_overflow", 64'(bus.rd_rsp_overflow), 64'(e[W]));
            end
        end
        if (snap_s || bus.snapshot_done === 1'b1)
            check("snapshot_done", 64'(bus.snapshot_done), 64'(snap_s));
    end

    task automatic cycle();
        @(negedge clk);
        bus.events_in    = '0;
        bus.clear_req    = 1'b0;
        bus.clear_mask   = '0;
        bus.snapshot_req = 1'b0;
        bus.rd_req       = 1'b0;
    endtask

    task automatic issue_read(input logic [IW-1:0] idx, input logic [W-1:0] d, input logic o);
        bus.rd_req = 1'b1;
        bus.rd_idx = idx;
        exp_q.push_back({o, d});
    endtask

    task automatic run_vec(input vec_t v);
        bus.clear_req  = 1'b1;
        bus.clear_mask = '1;
        cycle();
        repeat (v.pulses) begin
            bus.events_in = v.mask;
            cycle();
        end
        cycle();
        bus.snapshot_req = 1'b1;
        cycle();
        issue_read(v.idx, v.data, v.ovf);
        cycle();
    endtask

    initial begin
        vecs[0] = '{5'b00101, 10,  3'd0, 8'd10,  1'b0};
        vecs[1] = '{5'b00101, 10,  3'd1, 8'd0,   1'b0};
        vecs[2] = '{5'b00101, 10,  3'd2, 8'd10,  1'b0};
        vecs[3] = '{5'b11111, 3,   3'd4, 8'd3,   1'b0};
        vecs[4] = '{5'b10000, 0,   3'd4, 8'd0,   1'b0};
        vecs[5] = '{5'b01000, 255, 3'd3, 8'd255, 1'b0};
        vecs[6] = '{5'b01000, 256, 3'd3, D256,   1'b1};
        vecs[7] = '{5'b01000, 300, 3'd3, D300,   1'b1};

        reset            = 1'b1;
        bus.events_in    = '0;
        bus.clear_req    = 1'b0;
        bus.clear_mask   = '0;
        bus.snapshot_req = 1'b0;
        bus.rd_req       = 1'b0;
        bus.rd_idx       = '0;
        repeat (3) cycle();
        check("reset_rd_rsp_valid", 64'(bus.rd_rsp_valid), 64'(0));
        check("reset_rd_rsp_data", 64'(bus.rd_rsp_data), 64'(0));
        check("reset_rd_rsp_overflow", 64'(bus.rd_rsp_overflow), 64'(0));
        check("reset_snapshot_done", 64'(bus.snapshot_done), 64'(0));
        reset = 1'b0;

        for (int i = 0; i < N; i++) begin
            issue_read(IW'(i), 8'd0, 1'b0);
            cycle();
        end
        cycle();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Clear drops overflow immediately; shadow keeps the last snapshot.
        bus.clear_req  = 1'b1;
        bus.clear_mask = 5'b01000;
        cycle();
        issue_read(3'd3, D300, 1'b0);
        cycle();

        // Clear vs simultaneous qualified event, with snapshot in the same cycle.
        repeat (8) begin
            bus.events_in = 5'b00001;
            cycle();
        end
        bus.clear_req    = 1'b1;
        bus.clear_mask   = 5'b00001;
        bus.snapshot_req = 1'b1;
        cycle();
        bus.events_in = 5'b00001;
        issue_read(3'd0, 8'd7, 1'b0);
        cycle();
        cycle();
        bus.snapshot_req = 1'b1;
        cycle();
        issue_read(3'd0, 8'd1, 1'b0);
        cycle();

        // One-stage input latency; read alongside a snapshot returns the old shadow.
        bus.events_in = 5'b00010;
        cycle();
        bus.snapshot_req = 1'b1;
        cycle();
        bus.snapshot_req = 1'b1;
        issue_read(3'd1, 8'd0, 1'b0);
        cycle();
        issue_read(3'd1, 8'd1, 1'b0);
        cycle();

        issue_read(3'd5, 8'd0, 1'b0);
        cycle();
        issue_read(3'd7, 8'd0, 1'b0);
        cycle();
        cycle();

        // Reset with events in the input stage and a read that must get no response.
        bus.events_in = 5'b11111;
        cycle();
        reset      = 1'b1;
        bus.rd_req = 1'b1;
        bus.rd_idx = 3'd0;
        cycle();
        check("midreset_rd_rsp_valid", 64'(bus.rd_rsp_valid), 64'(0));
        check("midreset_rd_rsp_data", 64'(bus.rd_rsp_data), 64'(0));
        cycle();
        reset = 1'b0;
        cycle();
        cycle();
        bus.snapshot_req = 1'b1;
        cycle();
        for (int i = 0; i < N; i++) begin
            issue_read(IW'(i), 8'd0, 1'b0);
            cycle();
        end

        repeat (3) cycle();
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
